ac97_in_deframer: RTL
=====================

Name: ac97_in_deframer

Overview:
- Receive-side AC-link deframer for the AC'97 controller. It sits beside the output framer on the same ac97_bitclk domain.
- It tracks ac97_sync, shifts in the codec's ac97_sdata_in serial stream, and recovers the 256-bit input frame: 16-bit tag plus twelve 20-bit slots.
- It publishes the tag, the codec status slots (1, 2) and the PCM capture slots (3, 4) as held registers, with a one-cycle frame strobe.
- It flags framing errors and resynchronises automatically.

Parameters:
- FRAME_BITS, 256, bits per AC-link frame. Fixed by the protocol; kept as a parameter for benches only.
- SLOT_BITS, 20, bits per data slot.
- TAG_BITS, 16, bits in the tag slot.

Ports:
- ac97_bitclk  in  1  AC-link bit clock, 12.288 MHz; the only clock.
- ac97_rst  in  1  asynchronous active-high reset.
- ac97_sync  in  1  frame sync as driven to the codec. High for the last bit of a frame plus tag bits 0..14.
- ac97_sdata_in  in  1  serial data from the codec, MSB of each slot first.
- ac97_in_strobe  out  1  one-cycle pulse: a complete, well-framed frame has been published.
- ac97_in_tag  out  16  tag of last good frame. Bit 15 = codec ready, bits 14:3 = slot 1..12 valid.
- ac97_in_codec_ready  out  1  equals ac97_in_tag[15].
- ac97_in_status_addr  out  20  slot 1 of the last frame whose tag marked slots 1 and 2 valid.
- ac97_in_status_data  out  20  slot 2 from that same frame.
- ac97_in_status_new  out  1  pulses with ac97_in_strobe when status_addr/data were updated.
- ac97_in_pcm_left  out  20  slot 3 of the last frame with slot 3 valid.
- ac97_in_pcm_right  out  20  slot 4 of the last frame with slot 4 valid.
- ac97_in_locked  out  1  high while in RECV after at least one good frame.
- ac97_in_frame_err  out  1  one-cycle pulse on any framing error.

Behaviour:
- Sampling and edge detect:
  - All logic samples on posedge ac97_bitclk; reset is async active-high.
  - sync_q is the registered ac97_sync.
  - Rising edge (rise) = ac97_sync & ~sync_q.
  - The sample taken in the rise cycle is bit 255 of the previous frame. The next sample is tag bit 15 (frame bit 0).
- State machine {HUNT, RECV}:
  - HUNT: ignore data. On rise, go to RECV with bit counter cnt = 0 on the next cycle.
  - RECV: shift ac97_sdata_in into a 256-bit shift register (MSB-first); cnt increments by one (8-bit).
  - RECV, cnt==255 and rise: frame complete. cnt wraps to 0; stay in RECV.
  - RECV, rise with cnt != 255: pulse frame_err, discard the partial frame, cnt = 0, stay in RECV (resync on the new edge).
  - RECV, cnt==255 without rise: pulse frame_err, discard, go to HUNT, clear locked.
- Publish:
  - Latency: publishing occurs one cycle after the bit-255 sample.
  - In that cycle ac97_in_strobe = 1, ac97_in_tag takes frame bits 0..15, and locked = 1.
  - status_addr/status_data are loaded, and status_new pulses, only if tag[15] & tag[14] & tag[13].
  - pcm_left is loaded only if tag[12]; pcm_right only if tag[11]. Otherwise these outputs hold their previous values.
  - Slots 5..12 are received (for alignment) but not published.
  - Discarded frames never change any published output.
- Reset, including mid-frame:
  - State = HUNT, cnt = 0, sync_q = 0.
  - All outputs 0: strobe, status_new, frame_err and locked low; all data registers zero.
- Simultaneous events: if rise at cnt==255 coincides with publish of the previous frame, both take effect; publishing uses the captured copy, not the live shift register.

Optional Feature:
- Macro: AC97_IN_DEFRAMER_STATS_EN.
- When defined, add outputs ac97_in_frame_count[15:0] and ac97_in_err_count[7:0].
  - frame_count increments on each strobe and wraps at 0xFFFF→0.
  - err_count increments on each frame_err and saturates at 0xFF.
  - Both are cleared by reset.
- When undefined, these ports and counters do not exist.

Decomposition:
- Shared package ac97_pkg holds:
  - constants AC97_FRAME_BITS = 256, AC97_SLOT_BITS = 20, AC97_TAG_BITS = 16;
  - tag bit indices AC97_TAG_READY = 15, AC97_TAG_SLOT1 = 14 … AC97_TAG_SLOT12 = 3;
  - frame bit offset of slot n = 16 + 20*(n-1);
  - enum ac97_rx_state_t {HUNT, RECV}.
- One natural sub-module: ac97_sync_tracker, owning sync_q, rise detection, cnt and the FSM. It outputs frame_done and frame_err to the deframer datapath.

Test Plan:
- Reset, then 3 well-formed frames with tag 0xE000, slot1 0x26000, slot2 0x0F0F0 → strobe every 256 cycles, status_addr = 0x26000, status_data = 0x0F0F0, status_new = 1, codec_ready = 1, locked = 1 after the first frame.
- Frame with tag 0x9800, slot3 0x12345, slot4 0xABCDE, followed by a frame with tag 0x8000 → pcm_left = 0x12345 and pcm_right = 0xABCDE after the first frame and held after the second; status registers unchanged.
- Early sync rise at cnt = 100 → frame_err pulse, no strobe, outputs unchanged; the next clean frame strobes normally 256 cycles after the early rise.
- Sync held low past cnt = 255 → frame_err, locked = 0, HUNT; the next rise relocks and the following frame strobes.
- Assert ac97_rst at cnt = 130 → all outputs 0 immediately; no strobe until a full frame follows a fresh rise.
- With AC97_IN_DEFRAMER_STATS_EN: 65537 good frames plus 300 errors → frame_count = 1, err_count = 0xFF.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared AC-link constants, slot layout helpers and receive FSM state type.
package ac97_pkg;

    localparam int AC97_FRAME_BITS = 256;
    localparam int AC97_SLOT_BITS  = 20;
    localparam int AC97_TAG_BITS   = 16;

    localparam int AC97_TAG_READY  = 15;
    localparam int AC97_TAG_SLOT1  = 14;
    localparam int AC97_TAG_SLOT2  = 13;
    localparam int AC97_TAG_SLOT3  = 12;
    localparam int AC97_TAG_SLOT4  = 11;

    typedef enum logic {
        HUNT,
        RECV
    } ac97_rx_state_t;

    // Frame bit position of the first (MSB) bit of data slot n, n = 1..12.
    function automatic int ac97_slot_offset(input int n);
        return AC97_TAG_BITS + AC97_SLOT_BITS * (n - 1);
    endfunction

endpackage

// File: rtl/ac97_sync_tracker.sv
// Follows ac97_sync edges and counts bit positions within the AC-link frame;
// reports frame completion and framing errors to the deframer datapath.
module ac97_sync_tracker
    import ac97_pkg::*;
#(
    parameter int FRAME_BITS = AC97_FRAME_BITS
) (
    input  logic       ac97_bitclk,
    input  logic       ac97_rst,
    input  logic       ac97_sync,
    output logic [7:0] cnt,
    output logic       shift_en,
    output logic       frame_done,
    output logic       frame_err,
    output logic       lose_lock
);

    localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

    ac97_rx_state_t state, next_state;
    logic           sync_q;
    logic           rise;
    logic [7:0]     next_cnt;

    assign rise = ac97_sync & ~sync_q;

    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) begin
            state  <= HUNT;
            cnt    <= 8'd0;
            sync_q <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            sync_q <= ac97_sync;
        end
    end

    // The sample in a rise cycle is bit 255 of the frame just ending, so a
    // rise anywhere but cnt==255 means the codec and we disagree on framing.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        lose_lock  = 1'b0;
        case (state)
            HUNT: begin
                next_cnt = 8'd0;
                if (rise) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                shift_en = 1'b1;
                if (cnt == LAST_BIT) begin
                    next_cnt = 8'd0;
                    if (rise) begin
                        frame_done = 1'b1;
                    end else begin
                        frame_err  = 1'b1;
                        lose_lock  = 1'b1;
                        next_state = HUNT;
                    end
                end else if (rise) begin
                    frame_err = 1'b1;
                    next_cnt  = 8'd0;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            default: begin
                next_state = HUNT;
                next_cnt   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/ac97_in_deframer.sv
// AC-link receive deframer: publishes tag, status slots 1/2 and PCM slots 3/4.
// Optional frame/error counters are enabled by defining AC97_IN_DEFRAMER_STATS_EN.
module ac97_in_deframer
    import ac97_pkg::*;
#(
    parameter int FRAME_BITS = AC97_FRAME_BITS,
    parameter int SLOT_BITS  = AC97_SLOT_BITS,
    parameter int TAG_BITS   = AC97_TAG_BITS
) (
    input  logic                 ac97_bitclk,
    input  logic                 ac97_rst,
    input  logic                 ac97_sync,
    input  logic                 ac97_sdata_in,
    output logic                 ac97_in_strobe,
    output logic [TAG_BITS-1:0]  ac97_in_tag,
    output logic                 ac97_in_codec_ready,
    output logic [SLOT_BITS-1:0] ac97_in_status_addr,
    output logic [SLOT_BITS-1:0] ac97_in_status_data,
    output logic                 ac97_in_status_new,
    output logic [SLOT_BITS-1:0] ac97_in_pcm_left,
    output logic [SLOT_BITS-1:0] ac97_in_pcm_right,
    output logic                 ac97_in_locked,
`ifdef AC97_IN_DEFRAMER_STATS_EN
    output logic [15:0]          ac97_in_frame_count,
    output logic [7:0]           ac97_in_err_count,
`endif
    output logic                 ac97_in_frame_err
);

    // Only the tag and slots 1..4 are published, so capture stops after those
    // bits; later slots are still counted for alignment but never stored.
    localparam int         CAP_BITS = TAG_BITS + 4 * SLOT_BITS;
    localparam logic [7:0] CAP_END  = 8'(CAP_BITS);
    localparam int         S1_MSB   = CAP_BITS - 1 - ac97_slot_offset(1);
    localparam int         S2_MSB   = CAP_BITS - 1 - ac97_slot_offset(2);
    localparam int         S3_MSB   = CAP_BITS - 1 - ac97_slot_offset(3);
    localparam int         S4_MSB   = CAP_BITS - 1 - ac97_slot_offset(4);

    logic [7:0]          cnt;
    logic                shift_en;
    logic                frame_done;
    logic                frame_err;
    logic                lose_lock;
    logic [CAP_BITS-1:0] cap;
    logic [TAG_BITS-1:0] cap_tag;

    ac97_sync_tracker #(
        .FRAME_BITS (FRAME_BITS)
    ) u_sync_tracker (
        .ac97_bitclk (ac97_bitclk),
        .ac97_rst    (ac97_rst),
        .ac97_sync   (ac97_sync),
        .cnt         (cnt),
        .shift_en    (shift_en),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .lose_lock   (lose_lock)
    );

    assign cap_tag             = cap[CAP_BITS-1 -: TAG_BITS];
    assign ac97_in_codec_ready = ac97_in_tag[AC97_TAG_READY];

    // The capture register is untouched from bit 96 to the frame end, so the
    // publish below never races with the start of the next frame.
    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) begin
            cap                 <= '0;
            ac97_in_strobe      <= 1'b0;
            ac97_in_tag         <= '0;
            ac97_in_status_addr <= '0;
            ac97_in_status_data <= '0;
            ac97_in_status_new  <= 1'b0;
            ac97_in_pcm_left    <= '0;
            ac97_in_pcm_right   <= '0;
            ac97_in_locked      <= 1'b0;
            ac97_in_frame_err   <= 1'b0;
        end else begin
            if (shift_en && cnt < CAP_END) begin
                cap <= {cap[CAP_BITS-2:0], ac97_sdata_in};
            end
            ac97_in_strobe     <= frame_done;
            ac97_in_frame_err  <= frame_err;
            ac97_in_status_new <= 1'b0;
            if (frame_done) begin
                ac97_in_tag    <= cap_tag;
                ac97_in_locked <= 1'b1;
                if (cap_tag[AC97_TAG_READY] & cap_tag[AC97_TAG_SLOT1] & cap_tag[AC97_TAG_SLOT2]) begin
                    ac97_in_status_addr <= cap[S1_MSB -: SLOT_BITS];
                    ac97_in_status_data <= cap[S2_MSB -: SLOT_BITS];
                    ac97_in_status_new  <= 1'b1;
                end
                if (cap_tag[AC97_TAG_SLOT3]) begin
                    ac97_in_pcm_left <= cap[S3_MSB -: SLOT_BITS];
                end
                if (cap_tag[AC97_TAG_SLOT4]) begin
                    ac97_in_pcm_right <= cap[S4_MSB -: SLOT_BITS];
                end
            end else if (lose_lock) begin
                ac97_in_locked <= 1'b0;
            end
        end
    end

`ifdef AC97_IN_DEFRAMER_STATS_EN
    // Frame count wraps naturally; error count sticks at all-ones.
    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) begin
            ac97_in_frame_count <= 16'd0;
            ac97_in_err_count   <= 8'd0;
        end else begin
            if (frame_done) begin
                ac97_in_frame_count <= ac97_in_frame_count + 16'd1;
            end
            if (frame_err && ac97_in_err_count != 8'hFF) begin
                ac97_in_err_count <= ac97_in_err_count + 8'd1;
            end
        end
    end
`endif

endmodule
